// File: rtl/rv523_pkg.sv
// Shared constants and types for the LED-visible register bank cells.
package rv523_pkg;
  localparam int LED_DIM_BITS_DEF = 4;
  localparam int STRETCH_W = 8;
  typedef logic [LED_DIM_BITS_DEF-1:0] led_duty_t;
endpackage

// File: rtl/led_pwm_ch.sv
// One LED channel: duty compare, optional activity stretch, output flop.
// Stretch counter is built only with REG_BANK_LED_STRETCH_EN defined.
module led_pwm_ch
  import rv523_pkg::*;
#(
  parameter int DIM_BITS    = LED_DIM_BITS_DEF,
  parameter int STRETCH_CYC = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lvl_raw,
  input  logic [DIM_BITS-1:0] pwm_cnt,
  input  logic [DIM_BITS-1:0] duty,
  input  logic                change,
  output logic                led
);

  logic on_w;
  logic lvl_w;
  logic led_q;

  // all-ones duty means always on, not 2^N-1 of 2^N cycles
  assign on_w = (&duty) ? 1'b1 : (pwm_cnt < duty);

`ifdef REG_BANK_LED_STRETCH_EN
  logic [STRETCH_W-1:0] sc_q;
  logic [STRETCH_W-1:0] sc_d;

  always_comb begin
    sc_d = sc_q;
    if (change) begin
      sc_d = STRETCH_W'(STRETCH_CYC);
    end else if (sc_q != '0) begin
      sc_d = sc_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end

  assign lvl_w = (lvl_raw & on_w) | (sc_q != '0);
`else
  logic                 unused_chg;
  logic [STRETCH_W-1:0] unused_cfg;
  assign unused_chg = change;
  assign unused_cfg = STRETCH_W'(STRETCH_CYC);
  assign lvl_w      = lvl_raw & on_w;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 1'b0;
    end else begin
      led_q <= lvl_w;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/reg_bank_led.sv
// WIDTH-bit load/scan register bank with a PWM-dimmed LED per bit.
// Optional activity stretch: define REG_BANK_LED_STRETCH_EN.
module reg_bank_led
  import rv523_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIM_BITS    = LED_DIM_BITS_DEF,
  parameter int STRETCH_CYC = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic [WIDTH-1:0]    d,
  input  logic                scan_en,
  input  logic                scan_in,
  output logic                scan_out,
  output logic [WIDTH-1:0]    q,
  input  logic [DIM_BITS-1:0] duty,
  output logic [WIDTH-1:0]    led
);

  logic [WIDTH-1:0]    q_q;
  logic [WIDTH-1:0]    q_d;
  logic [WIDTH-1:0]    shift_w;
  logic [WIDTH-1:0]    chg_w;
  logic [DIM_BITS-1:0] pwm_q;

  if (WIDTH == 1) begin : g_sh1
    assign shift_w = scan_in;
  end else begin : g_shn
    assign shift_w = {q_q[WIDTH-2:0], scan_in};
  end

  always_comb begin
    q_d = q_q;
    if (scan_en) begin
      q_d = shift_w;
    end else if (load_en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      pwm_q <= '0;
    end else begin
      q_q   <= q_d;
      pwm_q <= pwm_q + 1'b1;
    end
  end

  assign chg_w    = q_d ^ q_q;
  assign q        = q_q;
  assign scan_out = q_q[WIDTH-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    led_pwm_ch #(
      .DIM_BITS   (DIM_BITS),
      .STRETCH_CYC(STRETCH_CYC)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .lvl_raw(q_q[i]),
      .pwm_cnt(pwm_q),
      .duty   (duty),
      .change (chg_w[i]),
      .led    (led[i])
    );
  end

endmodule

// File: tb/tb_reg_bank_led.sv
// Self-checking bench for reg_bank_led (WIDTH=8, DIM_BITS=4).
// Stretch checks run when REG_BANK_LED_STRETCH_EN is defined.
module tb_reg_bank_led;
  localparam int W  = 8;
  localparam int SC = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_en;
  logic [W-1:0] d;
  logic         scan_en;
  logic         scan_in;
  logic         scan_out;
  logic [W-1:0] q;
  logic [3:0]   duty;
  logic [W-1:0] led;

  int n_chk  = 0;
  int n_fail = 0;

  reg_bank_led #(.WIDTH(W), .DIM_BITS(4), .STRETCH_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .d(d),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
    .q(q), .duty(duty), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: stored value, PWM phase and edges since last bit change
  logic [W-1:0] mq;
  logic [W-1:0] mled;
  int           mpwm;
  int           age [W];

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] nq;
    logic [W-1:0] nl;
    bit           on;
    if (!rst_n) begin
      mq   = '0;
      mled = '0;
      mpwm = 0;
      for (int i = 0; i < W; i++) age[i] = 1000;
    end else begin
      on = (duty == 4'd15) ? 1'b1 : (mpwm < int'(duty));
      for (int i = 0; i < W; i++) begin
        nl[i] = mq[i] & on;
`ifdef REG_BANK_LED_STRETCH_EN
        if (age[i] < SC) nl[i] = 1'b1;
`endif
      end
      if (scan_en)      nq = {mq[W-2:0], scan_in};
      else if (load_en) nq = d;
      else              nq = mq;
      for (int i = 0; i < W; i++) begin
        if (nq[i] != mq[i]) age[i] = 0;
        else if (age[i] < 1000) age[i]++;
      end
      mq   = nq;
      mled = nl;
      mpwm = (mpwm + 1) % 16;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_q", 32'(q), 32'(mq));
      chk("m_scan_out", 32'(scan_out), 32'(mq[W-1]));
      chk("m_led", 32'(led), 32'(mled));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic count_led(input int bitn, input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (led[bitn]) c++;
    end
  endtask

  initial begin
    logic [W-1:0] a5;
    logic [7:0]   pat;
    int           c;
    int           last;
    int           hits;
    a5      = 8'hA5;
    pat     = 8'b1011_0010;
    rst_n   = 1'b0;
    load_en = 1'b1;
    d       = 8'hA5;
    scan_en = 1'b0;
    scan_in = 1'b0;
    duty    = 4'd0;
    repeat (3) tick();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_scan_out", 32'(scan_out), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("load_a5", 32'(q), 32'hA5);
    chk("load_scan_out", 32'(scan_out), 32'h1);

    d = 8'h00;
    tick();
    scan_en = 1'b1;
    d       = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      scan_in = pat[7-k];
      tick();
      chk("scan0_out", 32'(scan_out), (k == 7) ? 32'h1 : 32'h0);
    end
    chk("scan_b2", 32'(q), 32'hB2);

    scan_en = 1'b0;
    d       = 8'hA5;
    tick();
    scan_en = 1'b1;
    scan_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("scan_emit", 32'(scan_out), 32'(a5[7-k]));
      tick();
    end
    chk("scan_clear", 32'(q), 32'h0);

    scan_en = 1'b0;
    d       = 8'h01;
    duty    = 4'd3;
    tick();
    load_en = 1'b0;
    repeat (20) tick();
    count_led(0, 16, c);
    chk("pwm_duty3", 32'(c), 32'd3);
    duty = 4'hF;
    repeat (2) tick();
    count_led(0, 16, c);
    chk("pwm_full", 32'(c), 32'd16);
    duty = 4'd0;
    repeat (2) tick();
    count_led(0, 16, c);
    chk("pwm_off", 32'(c), 32'd0);

    duty = 4'd1;
    repeat (2) tick();
    last = -1;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (led[0]) begin
        if (last >= 0) chk("wrap_gap", 32'(k - last), 32'd16);
        last = k;
        hits++;
      end
    end
    chk("wrap_hits", 32'(hits >= 2), 32'h1);

`ifdef REG_BANK_LED_STRETCH_EN
    duty    = 4'd0;
    load_en = 1'b1;
    d       = 8'h00;
    repeat (20) tick();
    d = 8'h08;
    tick();
    load_en = 1'b0;
    count_led(3, 30, c);
    chk("stretch15", 32'(c), 32'd15);

    load_en = 1'b1;
    d       = 8'h00;
    repeat (20) tick();
    d = 8'h08;
    tick();
    c       = led[3] ? 1 : 0;
    load_en = 1'b0;
    for (int k = 1; k < 40; k++) begin
      load_en = (k == 10);
      d       = 8'h00;
      tick();
      if (led[3]) c++;
    end
    chk("stretch_retrig", 32'(c), 32'd25);

    load_en = 1'b1;
    d       = 8'h00;
    repeat (20) tick();
    d = 8'h08;
    tick();
    load_en = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_led", 32'(led), 32'h0);
    chk("rst_mid_q", 32'(q), 32'h0);
    tick();
    rst_n = 1'b1;
    count_led(3, 20, c);
    chk("rst_no_flash", 32'(c), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
